// File: rtl/butterfly_pipe.sv
// Pipelined radix-2 DIT butterfly: a' = a + b*w, b' = a - b*w.
// Three register stages (products, rotate/round, add/sub/scale) under one
// global stall, with a tag sideband and a sticky saturation flag.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. in_ready_o = out_ready_i | ~out_valid_o, so the whole pipe advances
// together or holds together. A held output keeps its data unchanged until it
// is consumed.
module butterfly_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 15,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [1:0][DATA_WIDTH-1:0]  a_i,
  input  logic [1:0][DATA_WIDTH-1:0]  b_i,
  input  logic [1:0][FRAC_BITS+1:0]   twid_i,
  input  logic                        inv_i,
  input  logic                        scale_i,
  input  logic [TAG_WIDTH-1:0]        tag_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [1:0][DATA_WIDTH-1:0]  a_o,
  output logic [1:0][DATA_WIDTH-1:0]  b_o,
  output logic [TAG_WIDTH-1:0]        tag_o,
  output logic                        ovf_o,
  input  logic                        clr_ovf_i
);

  localparam int DW = DATA_WIDTH;
  localparam int TW = FRAC_BITS + 2;
  localparam int PW = DW + TW;          // product width
  localparam int SW = PW + 1;           // rotation sum width
  localparam int RW = SW - FRAC_BITS;   // width after the rounding shift

  localparam logic signed [SW-1:0] RND_HALF =
    {{(SW - FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}};

  // True when an RW-bit signed value fits into DW bits.
  function automatic logic fits(input logic [RW-1:0] v);
    return (&v[RW-1:DW-1]) | ~(|v[RW-1:DW-1]);
  endfunction

  // Clamp an RW-bit signed value to the DW-bit range.
  function automatic logic [DW-1:0] sat(input logic [RW-1:0] v);
    if (fits(v)) return v[DW-1:0];
    else if (v[RW-1]) return {1'b1, {(DW-1){1'b0}}};
    else return {1'b0, {(DW-1){1'b1}}};
  endfunction

  // Sign-extend a DW+1 add/sub result to RW bits so sat/fits can be reused.
  function automatic logic [RW-1:0] sx(input logic [DW:0] s);
    return {{(RW-DW-1){s[DW]}}, s};
  endfunction

  // (s + 1) >>> 1 on a DW+1 value; the result always fits DW bits.
  function automatic logic [DW-1:0] halve(input logic [DW:0] s);
    logic [DW:0] t;
    t = s + {{DW{1'b0}}, 1'b1};
    return DW'(t >> 1);
  endfunction

  function automatic logic [DW-1:0] fin(input logic [DW:0] s, input logic sc);
    return sc ? halve(s) : sat(sx(s));
  endfunction

  // Global advance: every stage moves when the output slot is free or drained.
  logic adv;
  assign adv        = out_ready_i | ~out_valid_o;
  assign in_ready_o = adv;

  // ---------------- Stage 1: four products ----------------
  logic signed [PW-1:0] bre_x, bim_x, wre_x, wim_x;
  assign bre_x = $signed({{TW{b_i[0][DW-1]}}, b_i[0]});
  assign bim_x = $signed({{TW{b_i[1][DW-1]}}, b_i[1]});
  assign wre_x = $signed({{DW{twid_i[0][TW-1]}}, twid_i[0]});
  assign wim_x = $signed({{DW{twid_i[1][TW-1]}}, twid_i[1]});

  logic                   s1_valid, s1_inv, s1_scale;
  logic signed [PW-1:0]   s1_rr, s1_ii, s1_ri, s1_ir;
  logic [1:0][DW-1:0]     s1_a;
  logic [TAG_WIDTH-1:0]   s1_tag;

  // Capture products and the per-transaction controls on acceptance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_inv   <= 1'b0;
      s1_scale <= 1'b0;
      s1_rr    <= '0;
      s1_ii    <= '0;
      s1_ri    <= '0;
      s1_ir    <= '0;
      s1_a     <= '0;
      s1_tag   <= '0;
    end else if (adv) begin
      s1_valid <= in_valid_i;
      s1_inv   <= inv_i;
      s1_scale <= scale_i;
      s1_rr    <= bre_x * wre_x;
      s1_ii    <= bim_x * wim_x;
      s1_ri    <= bre_x * wim_x;
      s1_ir    <= bim_x * wre_x;
      s1_a     <= a_i;
      s1_tag   <= tag_i;
    end
  end

  // ---------------- Stage 2: rotate, round, saturate ----------------
  logic signed [SW-1:0] p_rr, p_ii, p_ri, p_ir, sum_re, sum_im;
  logic [RW-1:0]        q_re, q_im;
  logic                 clip2;
  assign p_rr = $signed({s1_rr[PW-1], s1_rr});
  assign p_ii = $signed({s1_ii[PW-1], s1_ii});
  assign p_ri = $signed({s1_ri[PW-1], s1_ri});
  assign p_ir = $signed({s1_ir[PW-1], s1_ir});

  // Multiply by w, or by conj(w) for the inverse transform.
  always_comb begin
    sum_re = '0;
    sum_im = '0;
    if (s1_inv) begin
      sum_re = p_rr + p_ii;
      sum_im = p_ir - p_ri;
    end else begin
      sum_re = p_rr - p_ii;
      sum_im = p_ri + p_ir;
    end
  end

  assign q_re  = RW'((sum_re + RND_HALF) >>> FRAC_BITS);
  assign q_im  = RW'((sum_im + RND_HALF) >>> FRAC_BITS);
  assign clip2 = s1_valid & ~(fits(q_re) & fits(q_im));

  logic                 s2_valid, s2_scale;
  logic [1:0][DW-1:0]   s2_a, s2_rot;
  logic [TAG_WIDTH-1:0] s2_tag;

  // Register the rounded, saturated rotation alongside a.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid <= 1'b0;
      s2_scale <= 1'b0;
      s2_a     <= '0;
      s2_rot   <= '0;
      s2_tag   <= '0;
    end else if (adv) begin
      s2_valid  <= s1_valid;
      s2_scale  <= s1_scale;
      s2_a      <= s1_a;
      s2_rot[0] <= sat(q_re);
      s2_rot[1] <= sat(q_im);
      s2_tag    <= s1_tag;
    end
  end

  // ---------------- Stage 3: add/sub, scale or saturate ----------------
  logic signed [DW:0] add_re, add_im, sub_re, sub_im;
  logic               clip3;
  assign add_re = $signed({s2_a[0][DW-1], s2_a[0]}) + $signed({s2_rot[0][DW-1], s2_rot[0]});
  assign add_im = $signed({s2_a[1][DW-1], s2_a[1]}) + $signed({s2_rot[1][DW-1], s2_rot[1]});
  assign sub_re = $signed({s2_a[0][DW-1], s2_a[0]}) - $signed({s2_rot[0][DW-1], s2_rot[0]});
  assign sub_im = $signed({s2_a[1][DW-1], s2_a[1]}) - $signed({s2_rot[1][DW-1], s2_rot[1]});
  assign clip3  = s2_valid & ~s2_scale &
                  ~(fits(sx(add_re)) & fits(sx(add_im)) & fits(sx(sub_re)) & fits(sx(sub_im)));

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      a_o         <= '0;
      b_o         <= '0;
      tag_o       <= '0;
    end else if (adv) begin
      out_valid_o <= s2_valid;
      a_o[0]      <= fin(add_re, s2_scale);
      a_o[1]      <= fin(add_im, s2_scale);
      b_o[0]      <= fin(sub_re, s2_scale);
      b_o[1]      <= fin(sub_im, s2_scale);
      tag_o       <= s2_tag;
    end
  end

  // Sticky overflow: a clip on an advancing stage sets it and beats a clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_o <= 1'b0;
    end else if (adv & (clip2 | clip3)) begin
      ovf_o <= 1'b1;
    end else if (clr_ovf_i) begin
      ovf_o <= 1'b0;
    end
  end

endmodule
